// File: rtl/fetch_pkg.sv
// Shared widths, the Decode NOP encoding and the prefetch-queue entry layout
// for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  // DLX "nop": SPECIAL opcode 0x00 with funct 0x15.
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0015;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc_plus_four;
  } fq_entry_t;

  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(4);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer with push, pop, synchronous flush, occupancy count and
// combinational head. Depth need not be a power of two.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, full, do_push, do_pop;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i & ~empty;
  // A full buffer may still accept a push in the same cycle as a pop.
  assign do_push = push_i & (~full | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wrap_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = wrap_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC, pipelined imem requests under a credit
// limit, prefetch queue towards Decode, redirect squash and bubble NOP mux.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned       DEPTH           = 4,
  parameter int unsigned       MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0] InitAddress     = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [ADDR_W-1:0]          imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [INSTR_W-1:0]         imem_rsp_data,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_target,
  input  logic                       bubble,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [INSTR_W-1:0]         dec_instr,
  output logic [ADDR_W-1:0]          dec_pc_plus_four,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [OUT_W-1:0]  drop_q, drop_d;

  logic [CNT_W-1:0]  q_count;
  logic [OUT_W-1:0]  tag_count;
  logic [ADDR_W-1:0] tag_head;
  fq_entry_t         q_head, q_wdata;

  logic credit_ok, req_fire, rsp_stale, rsp_keep, q_nonempty, dec_pop;

  // Credits count both queued words and reads still in flight, so every
  // accepted request is guaranteed a queue slot when its word returns.
  assign credit_ok = ((32'(q_count) + 32'(out_q)) < 32'(DEPTH)) &&
                     (32'(out_q) < 32'(MAX_OUTSTANDING));
  assign imem_req_valid = reset & credit_ok & ~redirect;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // Stale words never touch the tag FIFO: it was flushed together with the
  // queue, so it only holds tags of post-redirect requests.
  assign rsp_stale = imem_rsp_valid & (drop_q != '0);
  assign rsp_keep  = imem_rsp_valid & (drop_q == '0) & (tag_count != '0);

  assign q_wdata = '{instr: imem_rsp_data, pc_plus_four: tag_head};

  always_comb begin
    pc_d = pc_q;
    if (redirect)      pc_d = redirect_target;
    else if (req_fire) pc_d = next_pc(pc_q);
  end

  always_comb begin
    out_d = out_q;
    if (req_fire)       out_d = out_d + OUT_W'(1);
    if (imem_rsp_valid) out_d = out_d - OUT_W'(1);
  end

  // No request fires during a redirect, so out_d is exactly the set of reads
  // left in flight, all of which now belong to the old path.
  always_comb begin
    drop_d = drop_q;
    if (redirect)       drop_d = out_d;
    else if (rsp_stale) drop_d = drop_q - OUT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= InitAddress;
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ADDR_W)
  ) u_tag_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (req_fire),
    .pop_i   (rsp_keep),
    .flush_i (redirect),
    .data_i  (next_pc(pc_q)),
    .head_o  (tag_head),
    .count_o (tag_count)
  );

  fetch_fifo #(
    .DEPTH ($bits(fq_entry_t) > 0 ? DEPTH : DEPTH),
    .WIDTH ($bits(fq_entry_t))
  ) u_prefetch_q (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (rsp_keep),
    .pop_i   (dec_pop),
    .flush_i (redirect),
    .data_i  (q_wdata),
    .head_o  (q_head),
    .count_o (q_count)
  );

  assign q_nonempty = (q_count != '0);
  assign dec_valid  = q_nonempty | bubble;
  assign dec_pop    = q_nonempty & dec_ready & ~bubble & ~redirect;
  assign occupancy  = q_count;

  always_comb begin
    dec_instr        = NOP_WORD;
    dec_pc_plus_four = '0;
    if (q_nonempty) begin
      dec_pc_plus_four = q_head.pc_plus_four;
      if (!bubble) dec_instr = q_head.instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue against a queue-level model of the fetch
// stream with an in-order, variable-latency instruction memory.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;
  localparam logic [31:0] INIT  = 32'h0000_0000;

  logic                       clk, reset;
  logic                       imem_req_valid, imem_req_ready;
  logic [31:0]                imem_req_addr;
  logic                       imem_rsp_valid;
  logic [31:0]                imem_rsp_data;
  logic                       redirect;
  logic [31:0]                redirect_target;
  logic                       bubble, dec_valid, dec_ready;
  logic [31:0]                dec_instr, dec_pc_plus_four;
  logic [$clog2(DEPTH+1)-1:0] occupancy;

  fetch_queue #(
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .InitAddress     (INIT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .redirect         (redirect),
    .redirect_target  (redirect_target),
    .bubble           (bubble),
    .dec_valid        (dec_valid),
    .dec_ready        (dec_ready),
    .dec_instr        (dec_instr),
    .dec_pc_plus_four (dec_pc_plus_four),
    .occupancy        (occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
    int unsigned due;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  req_t        pend[$];
  ent_t        mq[$];
  logic [31:0] exp_pc;
  int unsigned epoch, cyc, last_due;
  logic        rst_cmd;
  logic        force_tgt;
  logic [31:0] tgt_val;
  int          n_checks, n_fail;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[17:2], ~a[17:2]} ^ 32'h5A00_00A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    pend.delete();
    mq.delete();
    exp_pc   = INIT;
    epoch    = epoch + 1;
    last_due = cyc;
  endtask

  // One clock cycle: drive, check outputs mid-cycle, then advance the model
  // to what the coming edge should produce.
  task automatic step(input int pr, input int lmin, input int lmax,
                      input int pd, input int pre, input int pb);
    req_t        r;
    logic        exp_rv, pop;
    int unsigned due;
    @(posedge clk);
    cyc++;
    #1;
    reset = rst_cmd;
    if (!rst_cmd) model_clear();
    imem_req_ready  = ($urandom_range(99) < pr);
    imem_rsp_valid  = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rsp_data   = imem_rsp_valid ? mem_word(pend[0].addr) : $urandom;
    redirect        = ($urandom_range(99) < pre);
    if (force_tgt)                   redirect_target = tgt_val;
    else if ($urandom_range(7) == 0) redirect_target = 32'hFFFF_FFF8;
    else                             redirect_target = $urandom & 32'h0000_FFFC;
    bubble          = ($urandom_range(99) < pb);
    dec_ready       = ($urandom_range(99) < pd);
    #1;
    exp_rv = rst_cmd && ((mq.size() + pend.size()) < DEPTH) && (pend.size() < MAXO) && !redirect;
    check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) check("req_addr", imem_req_addr, exp_pc);
    check("dec_valid", 32'(dec_valid), 32'((mq.size() > 0) || bubble));
    check("occupancy", 32'(occupancy), 32'(mq.size()));
    if (bubble) begin
      check("bubble_instr", dec_instr, NOP_WORD);
      check("bubble_pc4", dec_pc_plus_four, (mq.size() > 0) ? mq[0].pc4 : 32'h0);
    end else if (mq.size() > 0) begin
      check("dec_instr", dec_instr, mq[0].instr);
      check("dec_pc4", dec_pc_plus_four, mq[0].pc4);
    end else begin
      check("empty_instr", dec_instr, NOP_WORD);
      check("empty_pc4", dec_pc_plus_four, 32'h0);
    end
    pop = !bubble && dec_ready && (mq.size() > 0) && !redirect;
    if (pop) void'(mq.pop_front());
    if (imem_rsp_valid) begin
      r = pend.pop_front();
      if (r.epoch == epoch && !redirect) mq.push_back('{instr: mem_word(r.addr), pc4: r.addr + 32'd4});
    end
    if (exp_rv && imem_req_ready) begin
      due = cyc + 32'($urandom_range(lmax, lmin));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{addr: exp_pc, epoch: epoch, due: due});
      exp_pc = exp_pc + 32'd4;
    end
    if (redirect) begin
      mq.delete();
      epoch  = epoch + 1;
      exp_pc = redirect_target;
    end
  endtask

  initial begin
    logic seen;
    n_checks = 0; n_fail = 0; cyc = 0; epoch = 0; last_due = 0;
    force_tgt = 1'b0; tgt_val = '0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
    redirect = 0; redirect_target = '0; bubble = 0; dec_ready = 0;
    reset = 1'b1;
    #2 reset = 1'b0;
    rst_cmd = 1'b0;
    model_clear();
    repeat (3) step(0, 1, 1, 0, 0, 0);

    // Straight-line fetch at one word per cycle from the reset address.
    rst_cmd = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(100, 1, 1, 100, 0, 0);
      if (i >= 3) check("tp_valid", 32'(dec_valid), 32'd1);
    end

    // Decode stalled: queue must fill to DEPTH and stop requesting.
    for (int i = 0; i < 12; i++) step(100, 1, 1, 0, 0, 0);
    check("fill_occ", 32'(occupancy), DEPTH);
    check("fill_reqv", 32'(imem_req_valid), 32'd0);

    // Reset while full: outputs return to reset values within the cycle.
    rst_cmd = 1'b0;
    step(100, 1, 1, 100, 0, 0);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_decv", 32'(dec_valid), 32'd0);
    check("rst_instr", dec_instr, NOP_WORD);
    step(0, 1, 1, 0, 0, 0);
    rst_cmd = 1'b1;
    step(0, 1, 1, 0, 0, 0);
    check("restart_addr", imem_req_addr, INIT);

    // Redirect to 0x100 with two reads in flight.
    step(100, 3, 3, 0, 0, 0);
    step(100, 3, 3, 0, 0, 0);
    check("inflight_reqv", 32'(imem_req_valid), 32'd1);
    step(100, 3, 3, 0, 0, 0);
    force_tgt = 1'b1; tgt_val = 32'h100;
    step(100, 3, 3, 0, 100, 0);
    force_tgt = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(100, 1, 1, 0, 0, 0);
      seen = dec_valid;
    end
    check("redir_seen", 32'(seen), 32'd1);
    check("redir_pc4", dec_pc_plus_four, 32'h104);

    // Bubble with head at 0x20.
    force_tgt = 1'b1; tgt_val = 32'h20;
    step(100, 1, 1, 0, 100, 0);
    force_tgt = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(100, 1, 1, 0, 0, 0);
      seen = dec_valid;
    end
    step(100, 1, 1, 100, 0, 100);
    check("bub_nop", dec_instr, 32'h0000_0015);
    check("bub_head_pc4", dec_pc_plus_four, 32'h24);
    step(100, 1, 1, 100, 0, 0);
    check("post_bub_instr", dec_instr, mem_word(32'h20));
    check("post_bub_pc4", dec_pc_plus_four, 32'h24);

    // Redirect coinciding with a response, then a second redirect while
    // stale reads are still being dropped.
    step(100, 3, 3, 100, 0, 0);
    step(100, 3, 3, 100, 0, 0);
    step(100, 3, 3, 100, 0, 0);
    force_tgt = 1'b1; tgt_val = 32'h200;
    step(100, 3, 3, 100, 100, 0);
    tgt_val = 32'h300;
    step(100, 3, 3, 100, 100, 0);
    force_tgt = 1'b0;
    for (int i = 0; i < 12; i++) step(100, 1, 2, 100, 0, 0);

    // Fully random traffic, including wrap-around redirect targets.
    for (int i = 0; i < 3000; i++) step(70, 1, 4, 70, 6, 10);

    // Drain: nothing may remain in flight.
    for (int i = 0; i < 12; i++) step(0, 1, 1, 100, 0, 0);
    check("drain_pend", 32'(pend.size()), 32'd0);
    check("drain_reqv", 32'(imem_req_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the pipelined DLX-style core, replacing the single-register fetch stage. It owns the PC, issues pipelined requests to instruction memory with up to MAX_OUTSTANDING reads in flight, buffers returned words in a DEPTH-entry prefetch queue, and presents them to Decode with a valid/ready handshake. Branch/jump redirects flush the queue and squash stale in-flight responses. Load-use bubbles are injected as NOPs without consuming queue entries.

## Interface
- DEPTH, 4, prefetch queue entries; power of two, ≥2
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory requests; 1..DEPTH
- InitAddress, 0, PC value after reset
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  request to instruction memory
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  32  word address of request (current PC)
- imem_rsp_valid  in  1  response word valid; in order, exactly one per accepted request, cannot be stalled
- imem_rsp_data  in  32  instruction word
- redirect  in  1  taken branch/jump/JR/trap from Decode
- redirect_target  in  32  new PC
- bubble  in  1  load-use bubble request from hazard unit
- dec_valid  out  1  instruction available to Decode
- dec_ready  in  1  Decode accepts instruction
- dec_instr  out  32  instruction word (NOP_WORD when bubbling or empty)
- dec_pc_plus_four  out  32  address of dec_instr plus 4
- occupancy  out  clog2(DEPTH+1)  valid queue entries

## Operation
- Request fire: imem_req_valid & imem_req_ready. imem_req_valid = !reset_active & (count + outstanding < DEPTH) & (outstanding < MAX_OUTSTANDING) & !redirect.
- On fire: PC ← PC+4 (mod 2^32, wrap allowed); outstanding += 1; request's PC+4 pushed into a side tag FIFO (depth MAX_OUTSTANDING).
- Response: if drop > 0, discard word, drop −= 1, outstanding −= 1; else push {data, tag PC+4} into queue, outstanding −= 1. Credit check guarantees the queue never overflows.
- Decode handshake: dec_valid = (count > 0) | bubble. Pop when count > 0 & dec_ready & !bubble.
- bubble = 1: dec_instr = NOP_WORD (opcode 0x00, funct 0x15), dec_pc_plus_four = head PC+4 (0 if empty), dec_valid = 1, no pop regardless of dec_ready.
- redirect = 1 (highest priority): queue and tag FIFO flushed (count ← 0), PC ← redirect_target, no request issued that cycle, drop ← outstanding after this cycle's response (all in-flight reads become stale), no pop that cycle.
- Simultaneous push and pop: both performed; count unchanged.
- Redirect while drop > 0: drop overwritten with new total outstanding.

## Timing
- Reset values: PC = InitAddress, count = 0, outstanding = 0, drop = 0, imem_req_valid = 0, dec_valid = 0 (unless bubble), dec_instr = NOP_WORD, dec_pc_plus_four = 0, occupancy = 0.
- imem_req_addr is the PC register output; the first request is presented in the first cycle after reset deasserts.
- Response to Decode: word written at the edge where imem_rsp_valid is seen; dec_valid the following cycle. No bypass, minimum 1-cycle latency.
- Redirect: first request to redirect_target is presented the cycle after redirect; dec_valid is low (absent bubble) until the first post-redirect response is queued.
- Sustained throughput: 1 instruction/cycle when memory latency ≤ MAX_OUTSTANDING cycles and Decode is always ready.
- Reset asserted mid-operation: all state cleared immediately; responses to pre-reset requests are the memory's responsibility (memory is reset together).

## Structure
- Package fetch_pkg: NOP_WORD = 32'h0000_0015, INSTR_W = 32, ADDR_W = 32, and the queue-entry struct {instr, pc_plus_four}.
- Sub-module fetch_fifo: circular buffer, parametrised depth/width, with push, pop, synchronous flush, count, head output; instantiated twice (prefetch queue, tag FIFO).
- Top contains PC, outstanding/drop counters, credit logic, bubble mux.

## Test plan
- Reset, memory ready with 1-cycle latency, dec_ready = 1 -> requests to 0x0, 0x4, 0x8 on consecutive cycles; Decode receives them back-to-back with pc_plus_four 0x4, 0x8, 0xC.
- dec_ready = 0 with DEPTH = 4, MAX_OUTSTANDING = 2 -> exactly 4 responses queued, imem_req_valid low once count + outstanding = 4, occupancy = 4, no overflow.
- Redirect to 0x100 with 2 requests in flight -> both responses discarded, queue empty, next request addr 0x100, first delivered pc_plus_four = 0x104.
- bubble = 1 for 1 cycle with head at 0x20 -> dec_instr = 0x00000015, head not popped; next cycle head instruction with pc_plus_four 0x24 delivered.
- Redirect and response arrive same cycle, then a second redirect before drop reaches 0 -> no stale word ever reaches Decode; outstanding returns to 0.
- Reset asserted while queue full -> all outputs at reset values in the same cycle; PC restarts at InitAddress.
